pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Pipeline sequencing controller for the 5-stage ARM CPU. Sits beside the
//   programCounter and the IF/ID, ID/EX and EX/MEM pipeline registers. Decides
//   each cycle whether to advance, stall or flush them. Covers three cases:
//   load-use hazards, taken branches resolved in EX, and multi-cycle MUL
//   occupancy of the EX stage. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//   MUL_LAT  4   cycles a MUL occupies EX (>=1; 1 means no MUL stall)
//   CNT_W    32  width of the stall_cycles performance counter
// PORTS
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous, active-high reset
//   id_Rn         in   5      Rn of instruction in ID (instr[9:5])
//   id_Rm         in   5      Rm of instruction in ID (instr[20:16])
//   id_usesRn     in   1      ID instruction reads Rn
//   id_usesRm     in   1      ID instruction reads Rm
//   ex_memRead    in   1      instruction in EX is a load
//   ex_Rd         in   5      destination register of instruction in EX
//   ex_isMul      in   1      instruction in EX is a MUL
//   ex_brTaken    in   1      branch in EX resolved taken this cycle
//   pcWrite       out  1      1 = PC loads nextPC
//   ifid_write    out  1      1 = IF/ID loads; 0 = hold
//   ifid_flush    out  1      1 = IF/ID loads a NOP
//   idex_write    out  1      1 = ID/EX loads; 0 = hold
//   idex_bubble   out  1      1 = ID/EX loads a NOP; overrides idex_write
//   exmem_bubble  out  1      1 = EX/MEM loads a NOP
//   mul_busy      out  1      1 while state==MULWAIT
//   stall_cycles  out  CNT_W  count of cycles with pcWrite==0 since reset
// BEHAVIOUR
//   State: RUN | MULWAIT; mul_cnt register of $clog2(MUL_LAT+1) bits.
//   Reset (async, held): state=RUN, mul_cnt=0, stall_cycles=0.
//     Outputs while reset=1: pcWrite=0, ifid_write=0, ifid_flush=1,
//     idex_write=0, idex_bubble=1, exmem_bubble=1, mul_busy=0.
//   Defaults: pcWrite=ifid_write=idex_write=1; flush/bubbles=0.
//   Outputs are combinational from state and inputs, in the same cycle.
//   Priority in RUN: branch > MUL > load-use.
//   - Branch: ex_brTaken=1 -> ifid_flush=1, idex_bubble=1; PC advances.
//   - MUL start: ex_isMul=1 and MUL_LAT>1 -> pcWrite=0, ifid_write=0,
//     idex_write=0, exmem_bubble=1; next state MULWAIT, mul_cnt<=MUL_LAT-1.
//   - Load-use: ex_memRead=1, ex_Rd!=31, and a match
//     (id_usesRn & id_Rn==ex_Rd) | (id_usesRm & id_Rm==ex_Rd)
//     -> pcWrite=0, ifid_write=0, idex_bubble=1. Single cycle; stay in RUN.
//     X31 (XZR) never causes a hazard.
//   MULWAIT: ex_brTaken, ex_memRead and ex_isMul are ignored (EX holds the MUL).
//   - mul_cnt>1: same stall as MUL start; mul_cnt decrements.
//   - mul_cnt==1: default outputs (the MUL result advances); next state RUN.
//   - Result: the MUL is in EX for exactly MUL_LAT cycles, with MUL_LAT-1
//     stall cycles.
//   - MUL_LAT==1: ex_isMul has no effect; MULWAIT is never entered.
//   stall_cycles: +1 on each clock edge where pcWrite==0 and reset==0.
//     Saturates at all-ones; never wraps.
//   Reset asserted mid-MULWAIT: immediately returns to RUN with mul_cnt=0.
// TESTING
//   1. reset pulse mid-run -> outputs at reset values at once; RUN,
//      stall_cycles=0 after release.
//   2. ex_memRead=1, ex_Rd=3, id_Rm=3, id_usesRm=1 -> one cycle of
//      pcWrite=0, idex_bubble=1; stall_cycles=1.
//   3. Same as 2 but ex_Rd=31, or id_usesRm=0 -> no stall.
//   4. MUL_LAT=4, ex_isMul pulse in RUN -> 3 stall cycles, mul_busy high for
//      2 of them, exmem_bubble=1 for 3 cycles, back to RUN on cycle 4.
//   5. ex_brTaken=1 together with a load-use match -> ifid_flush=1,
//      idex_bubble=1, pcWrite=1 (branch wins).
//   6. CNT_W=4, hold a stall for 20 cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX hazard sources in, pipeline-register and PC
// enables out. The master side belongs to the datapath, the slave side to the controller.
interface pipe_hazard_ctrl_if;
   logic [4:0] id_Rn;
   logic [4:0] id_Rm;
   logic       id_usesRn;
   logic       id_usesRm;
   logic       ex_memRead;
   logic [4:0] ex_Rd;
   logic       ex_isMul;
   logic       ex_brTaken;

   logic       pcWrite;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_write;
   logic       idex_bubble;
   logic       exmem_bubble;
   logic       mul_busy;

   modport master (
      output id_Rn, id_Rm, id_usesRn, id_usesRm, ex_memRead, ex_Rd, ex_isMul, ex_brTaken,
      input  pcWrite, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy
   );

   modport slave (
      input  id_Rn, id_Rm, id_usesRn, id_usesRm, ex_memRead, ex_Rd, ex_isMul, ex_brTaken,
      output pcWrite, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle MUL occupancy of EX, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   pipe_hazard_ctrl_if.slave hz,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int  CW     = $clog2(MUL_LAT + 1);
   localparam bit  MUL_EN = (MUL_LAT > 1);

   typedef enum logic {RUN, MULWAIT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy;
   logic load_use;

   // XZR is never a real producer, so it cannot create a hazard.
   assign load_use = hz.ex_memRead && (hz.ex_Rd != 5'd31) &&
                     ((hz.id_usesRn && (hz.id_Rn == hz.ex_Rd)) ||
                      (hz.id_usesRm && (hz.id_Rm == hz.ex_Rd)));

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      mul_busy     = 1'b0;
      state_d      = state_q;
      mul_cnt_d    = mul_cnt_q;

      if (reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_write   = 1'b0;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (hz.ex_brTaken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (hz.ex_isMul && MUL_EN) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_bubble = 1'b1;
                  state_d      = MULWAIT;
                  mul_cnt_d    = CW'(MUL_LAT - 1);
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            MULWAIT: begin
               // EX is held by the MUL; its last cycle lets the result advance.
               mul_busy = 1'b1;
               if (mul_cnt_q > CW'(1)) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_bubble = 1'b1;
                  mul_cnt_d    = mul_cnt_q - CW'(1);
               end else begin
                  state_d   = RUN;
                  mul_cnt_d = '0;
               end
            end
            default: state_d = RUN;
         endcase
      end

      stall_d = stall_q;
      if (!pc_write && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         mul_cnt_q <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
         stall_q   <= stall_d;
      end
   end

   assign hz.pcWrite      = pc_write;
   assign hz.ifid_write   = ifid_write;
   assign hz.ifid_flush   = ifid_flush;
   assign hz.idex_write   = idex_write;
   assign hz.idex_bubble  = idex_bubble;
   assign hz.exmem_bubble = exmem_bubble;
   assign hz.mul_busy     = mul_busy;
   assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a MUL_LAT=4/CNT_W=32 instance and a MUL_LAT=1/CNT_W=4
// instance share stimulus and are compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus ();
   pipe_hazard_ctrl_if bus_s ();
   logic [31:0] stall_main;
   logic [3:0]  stall_sat;

   assign bus_s.id_Rn      = bus.id_Rn;
   assign bus_s.id_Rm      = bus.id_Rm;
   assign bus_s.id_usesRn  = bus.id_usesRn;
   assign bus_s.id_usesRm  = bus.id_usesRm;
   assign bus_s.ex_memRead = bus.ex_memRead;
   assign bus_s.ex_Rd      = bus.ex_Rd;
   assign bus_s.ex_isMul   = bus.ex_isMul;
   assign bus_s.ex_brTaken = bus.ex_brTaken;

   pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .hz(bus), .stall_cycles(stall_main));
   pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .hz(bus_s), .stall_cycles(stall_sat));

   // Output vectors are {pcWrite, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy}.
   localparam logic [6:0] O_RESET = 7'b0010110;
   localparam logic [6:0] O_DFLT  = 7'b1101000;
   localparam logic [6:0] O_LU    = 7'b0001100;
   localparam logic [6:0] O_BR    = 7'b1111100;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     rem   = 0;   // cycles the current MUL still holds EX after this one
   longint cnt_m = 0;
   int     cnt_s = 0;

   function automatic logic [6:0] model_out(input int lat, input int r);
      logic hit;
      if (reset) return O_RESET;
      if (r > 0) return (r > 1) ? 7'b0000011 : 7'b1101001;
      hit = bus.ex_memRead && (bus.ex_Rd != 5'd31) &&
            ((bus.id_usesRn && bus.id_Rn == bus.ex_Rd) || (bus.id_usesRm && bus.id_Rm == bus.ex_Rd));
      if (bus.ex_brTaken) return O_BR;
      if (bus.ex_isMul && lat > 1) return 7'b0000010;
      if (hit) return O_LU;
      return O_DFLT;
   endfunction

   function automatic logic [6:0] got_m();
      return {bus.pcWrite, bus.ifid_write, bus.ifid_flush, bus.idex_write,
              bus.idex_bubble, bus.exmem_bubble, bus.mul_busy};
   endfunction

   function automatic logic [6:0] got_s();
      return {bus_s.pcWrite, bus_s.ifid_write, bus_s.ifid_flush, bus_s.idex_write,
              bus_s.idex_bubble, bus_s.exmem_bubble, bus_s.mul_busy};
   endfunction

   task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic urn, input logic urm,
                        input logic mr, input logic [4:0] rd, input logic mul, input logic br);
      bus.id_Rn = rn; bus.id_Rm = rm; bus.id_usesRn = urn; bus.id_usesRm = urm;
      bus.ex_memRead = mr; bus.ex_Rd = rd; bus.ex_isMul = mul; bus.ex_brTaken = br;
   endtask

   task automatic set_reset(input logic v);
      reset = v;
      if (v) begin rem = 0; cnt_m = 0; cnt_s = 0; end
   endtask

   // Update the model with the inputs present before the edge, then move past it.
   task automatic advance();
      logic [6:0] em, es;
      em = model_out(4, rem);
      es = model_out(1, 0);
      if (!reset) begin
         if (!em[6] && cnt_m < 64'hFFFF_FFFF) cnt_m++;
         if (!es[6] && cnt_s < 15) cnt_s++;
         if (rem > 0) rem--;
         else if (!bus.ex_brTaken && bus.ex_isMul) rem = 3;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_reset(1'b1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (got_m() !== O_RESET) begin n_bad++; $display("FAIL reset_outs got=%b exp=%b", got_m(), O_RESET); end
      n_cmp++; if (got_s() !== O_RESET) begin n_bad++; $display("FAIL reset_outs_s got=%b exp=%b", got_s(), O_RESET); end
      n_cmp++; if (stall_main !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_main); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_reset(1'b0);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_DFLT) begin n_bad++; $display("FAIL run_after_reset got=%b exp=%b", got_m(), O_DFLT); end
      advance();
   endtask

   task automatic test_load_use();
      drive(5'd7, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_LU) begin n_bad++; $display("FAIL load_use got=%b exp=%b", got_m(), O_LU); end
      n_cmp++; if (got_s() !== O_LU) begin n_bad++; $display("FAIL load_use_s got=%b exp=%b", got_s(), O_LU); end
      advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++; if (stall_main !== 32'd1) begin n_bad++; $display("FAIL load_use_cnt got=%0d exp=1", stall_main); end
      n_cmp++; if (got_m() !== O_DFLT) begin n_bad++; $display("FAIL load_use_single got=%b exp=%b", got_m(), O_DFLT); end
      advance();
   endtask

   task automatic test_no_hazard();
      drive(5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_DFLT) begin n_bad++; $display("FAIL xzr_no_stall got=%b exp=%b", got_m(), O_DFLT); end
      advance();
      drive(5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_DFLT) begin n_bad++; $display("FAIL unused_rm_no_stall got=%b exp=%b", got_m(), O_DFLT); end
      n_cmp++; if (stall_main !== 32'd1) begin n_bad++; $display("FAIL no_hazard_cnt got=%0d exp=1", stall_main); end
      advance();
   endtask

   task automatic test_mul();
      int stalls = 0, busy_stalls = 0, exb = 0;
      logic [6:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, (i == 0), 0);
         @(negedge clk);
         e = model_out(4, rem);
         n_cmp++; if (got_m() !== e) begin n_bad++; $display("FAIL mul_cyc%0d got=%b exp=%b", i, got_m(), e); end
         if (!bus.pcWrite) begin stalls++; if (bus.mul_busy) busy_stalls++; end
         if (bus.exmem_bubble) exb++;
         if (i == 3) begin
            n_cmp++; if (got_m() !== 7'b1101001) begin n_bad++; $display("FAIL mul_release got=%b exp=1101001", got_m()); end
         end
         n_cmp++; if (got_s() !== O_DFLT) begin n_bad++; $display("FAIL mul_lat1_ignored got=%b exp=%b", got_s(), O_DFLT); end
         advance();
      end
      n_cmp++; if (stalls != 3) begin n_bad++; $display("FAIL mul_stalls got=%0d exp=3", stalls); end
      n_cmp++; if (busy_stalls != 2) begin n_bad++; $display("FAIL mul_busy_stalls got=%0d exp=2", busy_stalls); end
      n_cmp++; if (exb != 3) begin n_bad++; $display("FAIL mul_exmem_bubbles got=%0d exp=3", exb); end
   endtask

   task automatic test_branch_priority();
      drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_BR) begin n_bad++; $display("FAIL branch_over_lu got=%b exp=%b", got_m(), O_BR); end
      advance();
      drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_BR) begin n_bad++; $display("FAIL branch_over_mul got=%b exp=%b", got_m(), O_BR); end
      advance();
   endtask

   task automatic test_reset_mid_mul();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      set_reset(1'b1);
      #1;
      n_cmp++; if (got_m() !== O_RESET) begin n_bad++; $display("FAIL reset_mid_mul got=%b exp=%b", got_m(), O_RESET); end
      n_cmp++; if (stall_main !== 32'd0) begin n_bad++; $display("FAIL reset_mid_mul_cnt got=%0d exp=0", stall_main); end
      advance();
      set_reset(1'b0);
      @(negedge clk);
      n_cmp++; if (got_m() !== O_DFLT) begin n_bad++; $display("FAIL run_after_mid_reset got=%b exp=%b", got_m(), O_DFLT); end
      advance();
   endtask

   task automatic test_saturation();
      drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++; if (stall_sat !== 4'd15) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=15", stall_sat); end
      n_cmp++; if (stall_main !== 32'(cnt_m)) begin n_bad++; $display("FAIL sat_main_cnt got=%0d exp=%0d", stall_main, cnt_m); end
      advance();
   endtask

   task automatic test_random();
      logic [6:0] e;
      int r;
      logic [4:0] regs [5];
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 5; k++) begin
            r = $urandom_range(0, 4);
            regs[k] = (r == 4) ? 5'd31 : 5'(r);
         end
         drive(regs[0], regs[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), regs[2], ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 15));
         set_reset($urandom_range(0, 99) < 3);
         @(negedge clk);
         e = model_out(4, rem);
         n_cmp++; if (got_m() !== e) begin n_bad++; $display("FAIL rand_outs cyc%0d got=%b exp=%b", i, got_m(), e); end
         e = model_out(1, 0);
         n_cmp++; if (got_s() !== e) begin n_bad++; $display("FAIL rand_outs_s cyc%0d got=%b exp=%b", i, got_s(), e); end
         n_cmp++; if (stall_main !== 32'(cnt_m)) begin n_bad++; $display("FAIL rand_cnt cyc%0d got=%0d exp=%0d", i, stall_main, cnt_m); end
         n_cmp++; if (stall_sat !== 4'(cnt_s)) begin n_bad++; $display("FAIL rand_cnt_s cyc%0d got=%0d exp=%0d", i, stall_sat, cnt_s); end
         advance();
      end
      set_reset(1'b0);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_mul();
      test_branch_priority();
      test_reset_mid_mul();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
